// File: rtl/sequence_gen.sv
// Four-nibble one-cold sequence generator: LFSR-driven GEN, timed SHOW, HOLD for player entry.
// Optional build macro SEQ_GEN_NOREPEAT_EN forbids equal adjacent nibbles.
module sequence_gen #(
    parameter int unsigned SHOW_CYCLES = 100000000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] Sequence_out,
    output logic        display,
    output logic        busy,
    output logic        seq_valid
);
    localparam int CNT_W = 27;

    typedef enum logic [1:0] {IDLE, GEN, SHOW, HOLD} state_t;

    state_t           state_q, state_d;
    logic [15:0]      seq_q, seq_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       sel;

    // Code index 0..3 selects which bit is cold: E, D, B, 7.
    function automatic logic [3:0] code_of(input logic [1:0] s);
        return ~(4'b0001 << s);
    endfunction

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef SEQ_GEN_NOREPEAT_EN
    logic [3:0] prev_nib;

    always_comb begin
        prev_nib = 4'hF;
        case (idx_q)
            2'd1:    prev_nib = seq_q[3:0];
            2'd2:    prev_nib = seq_q[7:4];
            2'd3:    prev_nib = seq_q[11:8];
            default: prev_nib = 4'hF;
        endcase
    end

    // Index wraps 3->0, giving the cyclic order E->D->B->7->E.
    always_comb begin
        sel = lfsr_q[1:0];
        if (idx_q != 2'd0 && code_of(lfsr_q[1:0]) == prev_nib)
            sel = lfsr_q[1:0] + 2'd1;
    end
`else
    always_comb begin
        sel = lfsr_q[1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    state_d = GEN;
                    seq_d   = 16'hFFFF;
                    idx_d   = 2'd0;
                end
            end
            GEN: begin
                seq_d[{idx_q, 2'b00} +: 4] = code_of(sel);
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = SHOW;
                    cnt_d   = CNT_W'(SHOW_CYCLES);
                end
            end
            SHOW: begin
                // Last display cycle: leave SHOW so display is high exactly SHOW_CYCLES cycles.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            seq_q   <= 16'hFFFF;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign Sequence_out = seq_q;
    assign busy         = (state_q == GEN) || (state_q == SHOW);
    assign display      = (state_q == SHOW);
    assign seq_valid    = (state_q == HOLD);

endmodule
